// File: rtl/psum_gather_3_if.sv
// Stream bundle for psum_gather_3: beat input side plus packed-group output side.
// The slave modport is the gather block's view; master is the environment driving it.
interface psum_gather_3_if #(
  parameter int DATA_W = 32,
  parameter int LANES  = 3
);
  logic                    s_valid;
  logic                    s_ready;
  logic [DATA_W-1:0]       s_data;
  logic                    s_last;
  logic                    m_valid;
  logic                    m_ready;
  logic [LANES*DATA_W-1:0] m_flat;
  logic [1:0]              m_lanes;

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_flat, m_lanes
  );

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_flat, m_lanes
  );
endinterface

// File: rtl/psum_gather_3.sv
// Packs signed partial sums into LANES-wide groups for the PE adder tree.
// A fill buffer plus an output register let input streaming continue while the output stalls.
module psum_gather_3 #(
  parameter int DATA_W = 32,
  parameter int LANES  = 3,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  psum_gather_3_if.slave   bus,
  output logic [CNT_W-1:0] grp_cnt
);
  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

  typedef logic [LANES-1:0][DATA_W-1:0] group_t;

  logic [IDX_W-1:0] idx;
  group_t           fill;
  group_t           fill_next;
  group_t           out_q;
  logic             pending;
  logic             out_valid;
  logic [1:0]       pend_lanes;
  logic [1:0]       out_lanes;
  logic [1:0]       lanes_now;
  logic             accept;
  logic             close;
  logic             out_free;
  logic             handoff;

  // s_ready depends on registered state only, so m_ready never reaches it combinationally.
  assign accept    = bus.s_valid && !pending;
  assign close     = accept && (bus.s_last || (idx == IDX_W'(LANES - 1)));
  assign handoff   = out_valid && bus.m_ready;
  assign out_free  = !out_valid || bus.m_ready;
  assign lanes_now = 2'(idx) + 2'd1;

  always_comb begin
    // NOTE: assign a default before any conditional write, otherwise a latch is inferred.
    fill_next = fill;
    if (accept) fill_next[idx] = bus.s_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= '0;
      fill       <= '0;
      pending    <= 1'b0;
      pend_lanes <= '0;
      out_q      <= '0;
      out_lanes  <= '0;
      out_valid  <= 1'b0;
      grp_cnt    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (handoff) grp_cnt <= grp_cnt + CNT_W'(1);

      if (close && out_free) begin
        out_q     <= fill_next;
        out_lanes <= lanes_now;
        out_valid <= 1'b1;
        fill      <= '0;
        idx       <= '0;
      end else if (pending && handoff) begin
        // Parked group moves up; out_valid stays high so there is no gap.
        out_q     <= fill;
        out_lanes <= pend_lanes;
        pending   <= 1'b0;
        fill      <= '0;
      end else begin
        if (handoff) out_valid <= 1'b0;
        if (close) begin
          pending    <= 1'b1;
          fill       <= fill_next;
          pend_lanes <= lanes_now;
          idx        <= '0;
        end else if (accept) begin
          fill <= fill_next;
          idx  <= idx + IDX_W'(1);
        end
      end
    end
  end

  assign bus.s_ready = !pending;
  assign bus.m_valid = out_valid;
  assign bus.m_flat  = out_q;
  assign bus.m_lanes = out_lanes;
endmodule

// File: tb/tb_psum_gather_3.sv
// Self-checking bench for psum_gather_3: vector table plus hand sequences, scoreboard on output.
// A second instance with a 4-bit counter sees identical stimulus to exercise counter wrap.
module tb_psum_gather_3;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic [31:0] s_data = '0;
  logic        s_last = 1'b0;
  logic        m_ready = 1'b0;
  logic [15:0] grp_cnt;
  logic [3:0]  grp_cnt_w;

  psum_gather_3_if #(.DATA_W(32), .LANES(3)) bus ();
  psum_gather_3_if #(.DATA_W(32), .LANES(3)) bus_w ();

  assign bus.s_valid   = s_valid;
  assign bus.s_data    = s_data;
  assign bus.s_last    = s_last;
  assign bus.m_ready   = m_ready;
  assign bus_w.s_valid = s_valid;
  assign bus_w.s_data  = s_data;
  assign bus_w.s_last  = s_last;
  assign bus_w.m_ready = m_ready;

  psum_gather_3 #(.DATA_W(32), .LANES(3), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .grp_cnt(grp_cnt)
  );

  psum_gather_3 #(.DATA_W(32), .LANES(3), .CNT_W(4)) u_dut_w (
    .clk(clk), .rst_n(rst_n), .bus(bus_w), .grp_cnt(grp_cnt_w)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [95:0] flat;
    logic [1:0]  lanes;
  } exp_t;

  typedef struct {
    int             n;
    logic [2:0][31:0] d;
    logic           last;
    logic [95:0]    flat;
    logic [1:0]     lanes;
  } grp_vec_t;

  exp_t     q[$];
  exp_t     mon_e;
  grp_vec_t tbl[5];
  int       n_checks = 0;
  int       n_fail = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic send_beat(input logic [31:0] d, input logic l, output int stalls);
    bit   done = 0;
    logic rdy;
    stalls  = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      rdy = bus.s_ready;
      @(posedge clk);
      #1;
      if (rdy) done = 1;
      else stalls++;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_beat_timeout: data %h not accepted within 200 cycles", d);
    end
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    s_last  = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    s_valid = 1'b0;
    s_last  = 1'b0;
    rst_n   = 1'b0;
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Scoreboard: every handoff must match the oldest expected group.
  always @(negedge clk) begin
    if (rst_n && bus.m_valid && m_ready) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_group: got %h lanes %0d, expected none", bus.m_flat, bus.m_lanes);
      end else begin
        mon_e = q.pop_front();
        check("out_flat", bus.m_flat, mon_e.flat);
        check("out_lanes", bus.m_lanes, mon_e.lanes);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    int stall_total;

    tbl[0] = '{3, {32'd100, 32'hFFFF_FFF9, 32'd5}, 1'b0,
               {32'd100, 32'hFFFF_FFF9, 32'd5}, 2'd3};
    tbl[1] = '{2, {32'hDEAD_BEEF, 32'hFFFF_FFFF, 32'h7FFF_FFFF}, 1'b1,
               {32'd0, 32'hFFFF_FFFF, 32'h7FFF_FFFF}, 2'd2};
    tbl[2] = '{1, {32'h1111_1111, 32'h2222_2222, 32'h1234_5678}, 1'b1,
               {32'd0, 32'd0, 32'h1234_5678}, 2'd1};
    tbl[3] = '{3, {32'd1, 32'd0, 32'h8000_0000}, 1'b1,
               {32'd1, 32'd0, 32'h8000_0000}, 2'd3};
    tbl[4] = '{3, {32'hFFFF_0000, 32'h0000_0001, 32'hCAFE_F00D}, 1'b0,
               {32'hFFFF_0000, 32'h0000_0001, 32'hCAFE_F00D}, 2'd3};

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_m_valid", bus.m_valid, 1'b0);
    check("rst_m_flat", bus.m_flat, 96'd0);
    check("rst_m_lanes", bus.m_lanes, 2'd0);
    check("rst_grp_cnt", grp_cnt, 16'd0);
    check("rst_grp_cnt_w", grp_cnt_w, 4'd0);
    rst_n = 1'b1;
    #1;
    check("rst_s_ready", bus.s_ready, 1'b1);

    // Table-driven groups, consumer always ready
    m_ready = 1'b1;
    for (int g = 0; g < 5; g++) begin
      q.push_back('{tbl[g].flat, tbl[g].lanes});
      for (int j = 0; j < tbl[g].n; j++)
        send_beat(tbl[g].d[j], tbl[g].last && (j == tbl[g].n - 1), st);
      check("tbl_latency_m_valid", bus.m_valid, 1'b1);
      check("tbl_grp_cnt", grp_cnt, g);
    end
    idle(4);
    check("tbl_drained", q.size(), 0);
    check("tbl_grp_cnt_final", grp_cnt, 16'd5);
    check("tbl_m_valid_drop", bus.m_valid, 1'b0);

    // Continuous streaming: 30 beats, 10 groups, never stalled
    do_reset();
    m_ready = 1'b1;
    stall_total = 0;
    for (int i = 0; i < 30; i++) begin
      if (i % 3 == 0)
        q.push_back('{{32'(1000 + i + 2), 32'(1000 + i + 1), 32'(1000 + i)}, 2'd3});
      send_beat(32'(1000 + i), 1'b0, st);
      stall_total += st;
    end
    idle(4);
    check("stream_stalls", stall_total, 0);
    check("stream_grp_cnt", grp_cnt, 16'd10);
    check("stream_drained", q.size(), 0);

    // Back-pressure: first group held, second parked in the fill buffer
    do_reset();
    m_ready = 1'b0;
    q.push_back('{{32'd3, 32'd2, 32'd1}, 2'd3});
    q.push_back('{{32'd6, 32'd5, 32'd4}, 2'd3});
    for (int i = 1; i <= 6; i++) send_beat(32'(i), 1'b0, st);
    check("bp_s_ready_low", bus.s_ready, 1'b0);
    check("bp_m_valid", bus.m_valid, 1'b1);
    check("bp_m_flat_held", bus.m_flat, {32'd3, 32'd2, 32'd1});
    check("bp_m_lanes", bus.m_lanes, 2'd3);
    s_valid = 1'b1;
    s_data  = 32'd99;
    repeat (3) @(posedge clk);
    #1;
    s_valid = 1'b0;
    check("bp_hold_flat", bus.m_flat, {32'd3, 32'd2, 32'd1});
    check("bp_hold_s_ready", bus.s_ready, 1'b0);
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    check("bp_xfer_flat", bus.m_flat, {32'd6, 32'd5, 32'd4});
    check("bp_xfer_m_valid", bus.m_valid, 1'b1);
    check("bp_xfer_s_ready", bus.s_ready, 1'b1);
    check("bp_xfer_grp_cnt", grp_cnt, 16'd1);
    m_ready = 1'b1;
    idle(3);
    check("bp_drained", q.size(), 0);
    check("bp_grp_cnt_final", grp_cnt, 16'd2);

    // Asynchronous reset in the middle of a group
    do_reset();
    m_ready = 1'b1;
    q.push_back('{{32'd30, 32'd20, 32'd10}, 2'd3});
    for (int i = 1; i <= 3; i++) send_beat(32'(10 * i), 1'b0, st);
    idle(2);
    m_ready = 1'b0;
    q.push_back('{{32'd60, 32'd50, 32'd40}, 2'd3});
    for (int i = 4; i <= 6; i++) send_beat(32'(10 * i), 1'b0, st);
    send_beat(32'd111, 1'b0, st);
    send_beat(32'd222, 1'b0, st);
    s_valid = 1'b0;
    check("mid_pre_grp_cnt", grp_cnt, 16'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_m_valid", bus.m_valid, 1'b0);
    check("mid_rst_grp_cnt", grp_cnt, 16'd0);
    check("mid_rst_m_flat", bus.m_flat, 96'd0);
    q.delete();
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    q.push_back('{{32'd9, 32'd8, 32'd7}, 2'd3});
    for (int i = 7; i <= 9; i++) send_beat(32'(i), 1'b0, st);
    idle(3);
    check("mid_drained", q.size(), 0);
    check("mid_grp_cnt", grp_cnt, 16'd1);

    // Counter wrap on the 4-bit instance: 17 single-lane groups
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      q.push_back('{{64'd0, 32'(500 + i)}, 2'd1});
      send_beat(32'(500 + i), 1'b1, st);
    end
    idle(3);
    check("wrap_grp_cnt_16", grp_cnt, 16'd17);
    check("wrap_grp_cnt_4", grp_cnt_w, 4'd1);
    check("wrap_drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end
endmodule
